memory_pipe_arbiter_n: RTL



---
 rtl/memory_pipe_arbiter_n_if.sv | 42 ++++
 rtl/memory_pipe_arbiter_n.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/memory_pipe_arbiter_n_if.sv
// Bus bundle for memory_pipe_arbiter_n: core-side request/response
// channels and the single memory request/response port.
interface memory_pipe_arbiter_n_if #(
    parameter int P_CH = 4
);
    logic [P_CH-1:0]    iCH_REQ;
    logic [P_CH-1:0]    oCH_LOCK;
    logic [2*P_CH-1:0]  iCH_ORDER;
    logic [4*P_CH-1:0]  iCH_MASK;
    logic [P_CH-1:0]    iCH_RW;
    logic [32*P_CH-1:0] iCH_ADDR;
    logic [32*P_CH-1:0] iCH_DATA;
    logic [P_CH-1:0]    oCH_VALID;
    logic [P_CH-1:0]    iCH_BUSY;
    logic [64*P_CH-1:0] oCH_DATA;
    logic               oMEMORY_REQ;
    logic               iMEMORY_LOCK;
    logic [1:0]         oMEMORY_ORDER;
    logic [3:0]         oMEMORY_MASK;
    logic               oMEMORY_RW;
    logic [31:0]        oMEMORY_ADDR;
    logic [31:0]        oMEMORY_DATA;
    logic               iMEMORY_VALID;
    logic               oMEMORY_BUSY;
    logic [63:0]        iMEMORY_DATA;

    modport master (
        input  iCH_REQ, iCH_ORDER, iCH_MASK, iCH_RW, iCH_ADDR, iCH_DATA,
        input  iCH_BUSY, iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_DATA,
        output oCH_LOCK, oCH_VALID, oCH_DATA, oMEMORY_REQ, oMEMORY_ORDER,
        output oMEMORY_MASK, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA,
        output oMEMORY_BUSY
    );

    modport slave (
        output iCH_REQ, iCH_ORDER, iCH_MASK, iCH_RW, iCH_ADDR, iCH_DATA,
        output iCH_BUSY, iMEMORY_LOCK, iMEMORY_VALID, iMEMORY_DATA,
        input  oCH_LOCK, oCH_VALID, oCH_DATA, oMEMORY_REQ, oMEMORY_ORDER,
        input  oMEMORY_MASK, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA,
        input  oMEMORY_BUSY
    );
endinterface

// File: rtl/memory_pipe_arbiter_n.sv
// N-channel memory pipe arbiter with in-order response routing via a tag FIFO.
// Define MEMORY_PIPE_ARBITER_N_RR_EN for round-robin, else fixed priority.
module memory_pipe_arbiter_n #(
    parameter int P_CH            = 4,
    parameter int P_CH_N          = 2,
    parameter int P_QUEUE_DEPTH   = 16,
    parameter int P_QUEUE_DEPTH_N = 4
)(
    input logic iCLOCK,
    input logic inRESET,
    memory_pipe_arbiter_n_if.master bus
);
    logic [P_CH_N-1:0]          q_mem [P_QUEUE_DEPTH];
    logic [P_QUEUE_DEPTH_N-1:0] q_wp;
    logic [P_QUEUE_DEPTH_N-1:0] q_rp;
    logic [P_QUEUE_DEPTH_N:0]   q_cnt;
    logic                       q_full;
    logic                       q_empty;
    logic [P_CH_N-1:0]          head;
    logic                       pop;
    logic                       push;
    logic                       ack;
    logic                       common_lock;
    logic [P_CH-1:0]            eligible;
    logic [P_CH-1:0]            rot;
    logic [P_CH-1:0]            grant;
    logic                       gnt_valid;
    logic [P_CH_N-1:0]          gnt_idx;
    logic [P_CH_N-1:0]          gnt_off;
    logic [P_CH-1:0]            rsp_valid;
    logic [63:0]                rsp_data [P_CH];

    assign q_full      = q_cnt == (P_QUEUE_DEPTH_N+1)'(P_QUEUE_DEPTH);
    assign q_empty     = q_cnt == '0;
    assign head        = q_mem[q_rp];
    assign common_lock = q_full || bus.iMEMORY_LOCK;
    assign pop         = bus.iMEMORY_VALID && !q_empty && !bus.iCH_BUSY[head];
    assign push        = gnt_valid && !bus.iCH_RW[gnt_idx];
    assign ack         = gnt_valid && bus.iCH_RW[gnt_idx];

    // A channel whose read response pops this cycle cannot also take a write-ack
    always_comb begin
        eligible = '0;
        for (int c = 0; c < P_CH; c++)
            eligible[c] = bus.iCH_REQ[c] && !bus.iCH_BUSY[c]
                          && !(pop && head == P_CH_N'(c));
    end

`ifdef MEMORY_PIPE_ARBITER_N_RR_EN
    logic [P_CH_N-1:0] rr_ptr;
    logic [2*P_CH-1:0] rot_dbl;
    logic [P_CH_N:0]   rr_sum;

    assign rot_dbl = {eligible, eligible} >> rr_ptr;
    assign rot     = rot_dbl[P_CH-1:0];

    always_comb begin
        rr_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        if (rr_sum >= (P_CH_N+1)'(P_CH))
            rr_sum = rr_sum - (P_CH_N+1)'(P_CH);
        gnt_idx = rr_sum[P_CH_N-1:0];
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET)
            rr_ptr <= '0;
        else if (gnt_valid)
            rr_ptr <= (gnt_idx == P_CH_N'(P_CH-1)) ? '0 : gnt_idx + 1'b1;
    end
`else
    assign rot     = eligible;
    assign gnt_idx = gnt_off;
`endif

    always_comb begin
        gnt_off   = '0;
        gnt_valid = 1'b0;
        for (int k = P_CH-1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_off   = P_CH_N'(k);
                gnt_valid = 1'b1;
            end
        end
        if (common_lock)
            gnt_valid = 1'b0;
    end

    assign grant        = gnt_valid ? (P_CH'(1) << gnt_idx) : '0;
    assign bus.oCH_LOCK = ~grant;

    // Request register replays its contents while the memory side is locked
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            bus.oMEMORY_REQ   <= 1'b0;
            bus.oMEMORY_ORDER <= '0;
            bus.oMEMORY_MASK  <= '0;
            bus.oMEMORY_RW    <= 1'b0;
            bus.oMEMORY_ADDR  <= '0;
            bus.oMEMORY_DATA  <= '0;
        end else if (!common_lock) begin
            bus.oMEMORY_REQ <= gnt_valid;
            if (gnt_valid) begin
                bus.oMEMORY_ORDER <= bus.iCH_ORDER[int'(gnt_idx)*2 +: 2];
                bus.oMEMORY_MASK  <= bus.iCH_MASK[int'(gnt_idx)*4 +: 4];
                bus.oMEMORY_RW    <= bus.iCH_RW[gnt_idx];
                bus.oMEMORY_ADDR  <= bus.iCH_ADDR[int'(gnt_idx)*32 +: 32];
                bus.oMEMORY_DATA  <= bus.iCH_DATA[int'(gnt_idx)*32 +: 32];
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            q_wp  <= '0;
            q_rp  <= '0;
            q_cnt <= '0;
        end else begin
            if (push)
                q_wp <= q_wp + 1'b1;
            if (pop)
                q_rp <= q_rp + 1'b1;
            unique case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (inRESET && push)
            q_mem[q_wp] <= gnt_idx;
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            rsp_valid <= '0;
            for (int c = 0; c < P_CH; c++)
                rsp_data[c] <= '0;
        end else begin
            for (int c = 0; c < P_CH; c++) begin
                if (!bus.iCH_BUSY[c]) begin
                    if (pop && head == P_CH_N'(c)) begin
                        rsp_valid[c] <= 1'b1;
                        rsp_data[c]  <= bus.iMEMORY_DATA;
                    end else if (ack && gnt_idx == P_CH_N'(c)) begin
                        rsp_valid[c] <= 1'b1;
                        rsp_data[c]  <= '0;
                    end else begin
                        rsp_valid[c] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.oCH_VALID    = rsp_valid & ~bus.iCH_BUSY;
    assign bus.oMEMORY_BUSY = !q_empty && bus.iCH_BUSY[head];

    for (genvar c = 0; c < P_CH; c++) begin : g_data
        assign bus.oCH_DATA[c*64 +: 64] = rsp_data[c];
    end
endmodule
